// File: rtl/ifetch_pkg.sv
// Shared types and sizing helpers for the instruction prefetch front end.
// The optional clock-gating feature is selected with IFETCH_CG_EN (see instr_prefetch).
package ifetch_pkg;

  localparam int unsigned IF_ADDR_WIDTH  = 32;
  localparam int unsigned IF_INSTR_WIDTH = 32;

  // Default-width view of a prefetch FIFO entry.
  typedef struct packed {
    logic [IF_ADDR_WIDTH-1:0]  pc;
    logic [IF_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  function automatic int unsigned inc_bytes(input int unsigned instr_width);
    return instr_width / 8;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Parametrised synchronous FIFO with flush, used for both the PC tag queue
// and the prefetch buffer. Flush has priority over push/pop.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          en_i,
  input  logic                          flush_i,
  input  logic                          push_i,
  input  logic [W-1:0]                  data_i,
  input  logic                          pop_i,
  output logic [W-1:0]                  head_o,
  output logic [cnt_width(DEPTH)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic          full;

  assign full    = (count_q == CW'(DEPTH));
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (en_i) begin
      if (flush_i) begin
        rd_q    <= '0;
        wr_q    <= '0;
        count_q <= '0;
      end else begin
        if (push_i) wr_q <= wr_q + 1'b1;
        if (pop_i)  rd_q <= rd_q + 1'b1;
        count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (en_i && push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assert property (@(posedge clk) disable iff (!reset_n)
    !(en_i && push_i && full && !flush_i));

endmodule

// File: rtl/instr_prefetch.sv
// Pipelined instruction fetch: owns the PC, issues credit-limited memory requests,
// buffers responses and hands them to decode. Define IFETCH_CG_EN for the clock-gate enable.
module instr_prefetch
  import ifetch_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            INSTR_WIDTH = 32,
  parameter int unsigned            DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic                   rsp_valid,
  input  logic [INSTR_WIDTH-1:0] rsp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic                   cg_en
);

  localparam int unsigned           INC        = inc_bytes(INSTR_WIDTH);
  localparam int unsigned           CW         = cnt_width(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INC);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(INC - 1));

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         drop_q, drop_d;
  logic                  run_q;

  logic [CW-1:0]         pf_count, tag_count;
  logic [ADDR_WIDTH-1:0] tag_head;
  entry_t                pf_head, pf_push_data;
  logic [CW:0]           used_sum;
  logic                  credit_ok, issue, rsp_keep, pop, reg_en;

  // Valid/ready: a request or an output transfer happens on a cycle where both
  // valid and ready are high; valid never depends on ready. Responses have no backpressure.
  assign used_sum  = {1'b0, pf_count} + {1'b0, outstanding_q};
  assign credit_ok = used_sum < (CW+1)'(DEPTH);
  assign req_valid = run_q && credit_ok && !branch_taken;
  assign req_addr  = fetch_pc_q;
  assign issue     = req_valid && req_ready;

  assign rsp_keep  = rsp_valid && (drop_q == '0) && !branch_taken;

  assign out_valid = (pf_count != '0) && !branch_taken;
  assign out_pc    = pf_head.pc;
  assign out_instr = pf_head.instr;
  assign pop       = out_valid && out_ready;

  assign pf_push_data = '{pc: tag_head, instr: rsp_data};

`ifdef IFETCH_CG_EN
  logic pf_full;
  assign pf_full = (pf_count == CW'(DEPTH));
  // Idle only when nothing can change; a pop still needs the registers running.
  assign cg_en   = !(pf_full && (outstanding_q == '0) && !branch_taken);
  assign reg_en  = cg_en || pop;
`else
  assign cg_en   = 1'b1;
  assign reg_en  = 1'b1;
`endif

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(issue) - CW'(rsp_valid);
    drop_d        = drop_q;
    if (branch_taken) begin
      fetch_pc_d = branch_target & ALIGN_MASK;
      drop_d     = outstanding_q - CW'(rsp_valid);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + STEP;
      if (rsp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC & ALIGN_MASK;
      outstanding_q <= '0;
      drop_q        <= '0;
      run_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      run_q         <= 1'b1;
      if (reg_en) fetch_pc_q <= fetch_pc_d;
    end
  end

  ifetch_fifo #(.W(ADDR_WIDTH), .DEPTH(DEPTH)) u_tag_q (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (reg_en),
    .flush_i (branch_taken),
    .push_i  (issue),
    .data_i  (fetch_pc_q),
    .pop_i   (rsp_keep),
    .head_o  (tag_head),
    .count_o (tag_count)
  );

  ifetch_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_pf_q (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (reg_en),
    .flush_i (branch_taken),
    .push_i  (rsp_keep),
    .data_i  (pf_push_data),
    .pop_i   (pop),
    .head_o  (pf_head),
    .count_o (pf_count)
  );

  assert property (@(posedge clk) disable iff (!reset_n)
    !(rsp_valid && (outstanding_q == '0)));

  // Every live tag belongs to an outstanding request that will not be dropped.
  assert property (@(posedge clk) disable iff (!reset_n)
    (({1'b0, tag_count} + {1'b0, drop_q}) == {1'b0, outstanding_q}));

endmodule
